// File: rtl/key_sched_ctrl.sv
// Round scheduler for the AES key-expansion engine.
// Steps the engine through rounds 1..NUM_ROUNDS, tracks which round keys
// are written, and reports completion, abort and per-round timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no schedule running; round_num=0, waits for start
// S_LAUNCH | one-cycle exp_enable pulse for the current round
// S_WAIT   | waiting for exp_done; timeout counter running
// S_DONE   | one-cycle done pulse after the last round
// S_ERR    | one-cycle timeout exit; error is set and stays set
module key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  exp_done,
  output logic                  exp_enable,
  output logic [3:0]            round_num,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [NUM_ROUNDS-1:0] ready_mask
);

  localparam int                    CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]            LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [NUM_ROUNDS-1:0] MASK_ONE   = NUM_ROUNDS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      exp_enable <= 1'b0;
      round_num  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ready_mask <= '0;
      wait_cnt   <= '0;
    end else begin
      // Pulses default low; only the launching/completing branch raises them.
      exp_enable <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          round_num <= 4'd0;
          busy      <= 1'b0;
          if (start && !abort) begin
            state      <= S_LAUNCH;
            round_num  <= 4'd1;
            ready_mask <= '0;
            error      <= 1'b0;
            exp_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            round_num  <= 4'd0;
            ready_mask <= '0;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          // abort beats exp_done, which beats the timeout.
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            round_num  <= 4'd0;
            ready_mask <= '0;
          end else if (exp_done) begin
            ready_mask <= ready_mask | (MASK_ONE << (round_num - 4'd1));
            if (round_num == LAST_ROUND) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_LAUNCH;
              round_num  <= round_num + 4'd1;
              exp_enable <= 1'b1;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state <= S_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          round_num <= 4'd0;
        end
        S_ERR: begin
          // Completed-round bits stay visible for diagnosis.
          state     <= S_IDLE;
          round_num <= 4'd0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          round_num <= 4'd0;
        end
      endcase
    end
  end

endmodule
